up_counter: RTL and testbench

UP_COUNTER -- requirements
Module: up_counter

---
 rtl/up_counter_pkg.sv | 8 +
 rtl/up_counter_if.sv | 15 +
 rtl/up_counter.sv | 61 ++++++
 tb/tb_up_counter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/up_counter_pkg.sv
// Shared definitions for the up_counter slice: default width and count type.
package up_counter_pkg;

    localparam int unsigned UP_COUNTER_DEFAULT_WIDTH = 4;

    typedef logic [UP_COUNTER_DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/up_counter_if.sv
// Output bundle of up_counter (count, terminal count, wrap pulse) for consumers.
interface up_counter_if
    import up_counter_pkg::*;
#(
    parameter int unsigned WIDTH = UP_COUNTER_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (output count, output tc, output wrap);
    modport slave  (input  count, input  tc, input  wrap);

endinterface

// File: rtl/up_counter.sv
// Free-running modulo (MAX_COUNT+1) up counter with terminal-count decode and wrap pulse.
// Build option: define UP_COUNTER_SATURATE_EN to hold at MAX_COUNT instead of wrapping.
module up_counter
    import up_counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = UP_COUNTER_DEFAULT_WIDTH,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("up_counter: WIDTH %0d outside 1..32", WIDTH);
    end

    if (MAX_COUNT < 64'd1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("up_counter: MAX_COUNT %0d outside 1..2**WIDTH-1", MAX_COUNT);
    end

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
`ifdef UP_COUNTER_SATURATE_EN
        if (count_q < MAX_C) begin
            count_d = count_q + WIDTH'(1);
        end
`else
        // Increment never exceeds MAX_C, so the sum always fits in WIDTH bits.
        if (count_q < MAX_C) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = '0;
            wrap_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == MAX_C);
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter: default-parameter instance plus a MAX_COUNT=9 instance.
module tb_up_counter;
    import up_counter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic reset9;
    int   checks = 0;
    int   errors = 0;

    up_counter_if #(.WIDTH(4)) bus  ();
    up_counter_if #(.WIDTH(4)) bus9 ();

    up_counter dut (
        .clk   (clk),
        .reset (reset),
        .count (bus.count),
        .tc    (bus.tc),
        .wrap  (bus.wrap)
    );

    up_counter #(.WIDTH(4), .MAX_COUNT(9)) dut9 (
        .clk   (clk),
        .reset (reset9),
        .count (bus9.count),
        .tc    (bus9.tc),
        .wrap  (bus9.wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset  = 1'b1;
        reset9 = 1'b1;

        // Reset state at t=10
        tick();
        check("rst_count", 32'(bus.count), 0);
        check("rst_tc",    32'(bus.tc),    0);
        check("rst_wrap",  32'(bus.wrap),  0);
        check("rst9_count", 32'(bus9.count), 0);
        check("rst9_tc",    32'(bus9.tc),    0);
        tick();
        reset = 1'b0;

        // First edges after release: 1 then 2
        tick();
        check("rel_count1", 32'(bus.count), 1);
        tick();
        check("rel_count2", 32'(bus.count), 2);
        check("rel_tc2",    32'(bus.tc),    0);

        // Free run to terminal value
        repeat (13) tick();
        check("run_count15", 32'(bus.count), 15);
        check("run_tc15",    32'(bus.tc),    1);
        check("run_wrap15",  32'(bus.wrap),  0);
`ifndef UP_COUNTER_SATURATE_EN
        tick();
        check("wrap_count0", 32'(bus.count), 0);
        check("wrap_pulse",  32'(bus.wrap),  1);
        check("wrap_tc0",    32'(bus.tc),    0);
        tick();
        check("post_count1", 32'(bus.count), 1);
        check("post_wrap",   32'(bus.wrap),  0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("sat_count", 32'(bus.count), 15);
            check("sat_tc",    32'(bus.tc),    1);
            check("sat_wrap",  32'(bus.wrap),  0);
        end
`endif

        // Reset from any state back to a known start
        reset = 1'b1;
        tick();
        check("rst2_count", 32'(bus.count), 0);
        check("rst2_wrap",  32'(bus.wrap),  0);
        check("rst2_tc",    32'(bus.tc),    0);
        reset = 1'b0;

        for (int i = 1; i <= 9; i++) begin
            tick();
            check("climb_count", 32'(bus.count), 32'(i));
        end

        // Reset mid-count at 9
        reset = 1'b1;
        tick();
        check("mid_count0", 32'(bus.count), 0);
        check("mid_wrap",   32'(bus.wrap),  0);
        reset = 1'b0;
        tick();
        check("mid_count1", 32'(bus.count), 1);
        tick();
        check("mid_count2", 32'(bus.count), 2);

        // Reset pulse entirely between edges is ignored
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        check("glitch_count3", 32'(bus.count), 3);

        // Reset exactly at terminal count: no wrap pulse
        repeat (12) tick();
        check("tc_count15", 32'(bus.count), 15);
        check("tc_tc",      32'(bus.tc),    1);
        reset = 1'b1;
        tick();
        check("rsttc_count0", 32'(bus.count), 0);
        check("rsttc_wrap",   32'(bus.wrap),  0);
        check("rsttc_tc",     32'(bus.tc),    0);
        reset = 1'b0;
        tick();
        check("rsttc_count1", 32'(bus.count), 1);
        check("rsttc_wrap1",  32'(bus.wrap),  0);
        tick();
        check("rsttc_wrap2",  32'(bus.wrap),  0);

        // MAX_COUNT = 9 instance
        reset9 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("m9_count", 32'(bus9.count), 32'(i));
            check("m9_tc",    32'(bus9.tc),    32'(i == 9));
            check("m9_wrap",  32'(bus9.wrap),  0);
        end
`ifndef UP_COUNTER_SATURATE_EN
        tick();
        check("m9_wrap_count0", 32'(bus9.count), 0);
        check("m9_wrap_pulse",  32'(bus9.wrap),  1);
        check("m9_wrap_tc",     32'(bus9.tc),    0);
        tick();
        check("m9_post_count1", 32'(bus9.count), 1);
        check("m9_post_wrap",   32'(bus9.wrap),  0);
`else
        repeat (3) begin
            tick();
            check("m9_sat_count", 32'(bus9.count), 9);
            check("m9_sat_tc",    32'(bus9.tc),    1);
            check("m9_sat_wrap",  32'(bus9.wrap),  0);
        end
`endif
        reset9 = 1'b1;
        tick();
        check("m9_rst_count", 32'(bus9.count), 0);
        check("m9_rst_wrap",  32'(bus9.wrap),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
